// File: rtl/framer_pkg.sv
// -----------------------------------------------------------------------------
// framer_pkg
//
// Shared defaults and helpers for the sample framer.
//
// Contents:
//   N_DEFAULT      sample width in bits (two's complement)
//   K_DEFAULT      samples per frame
//   DEPTH_DEFAULT  FIFO entries (power of two, >= 2)
//   IDXW_DEFAULT   index width, ceil(log2(K_DEFAULT))
//   IDX_LAST       index of the final sample in a default-sized frame
//   clamp_nonneg() forces a negative two's-complement sample to zero
// -----------------------------------------------------------------------------
package framer_pkg;

    localparam int N_DEFAULT     = 16;
    localparam int K_DEFAULT     = 42;
    localparam int DEPTH_DEFAULT = 8;
    localparam int IDXW_DEFAULT  = 6;

    localparam logic [IDXW_DEFAULT-1:0] IDX_LAST = IDXW_DEFAULT'(K_DEFAULT - 1);

    // Width-generic clamp: the caller zero-extends its sample into 64 bits and
    // passes the real width, so the sign bit is found at position width-1.
    // Samples wider than 64 bits are not supported.
    function automatic logic [63:0] clamp_nonneg(input logic [63:0] sample,
                                                 input int unsigned width);
        logic [5:0] msb;
        msb = 6'(width - 1);
        return sample[msb] ? 64'd0 : sample;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with combinational read data (first-word fall-through).
// A pushed word is visible on rd_data after the clock edge that wrote it.
// A simultaneous push and pop keeps the occupancy constant. When full, a pop
// frees a slot for the following cycle only; the caller's push is ignored
// while full, so there is no same-cycle bypass.
//
// Parameters:
//   WIDTH  word width in bits
//   DEPTH  number of entries; must be a power of two and >= 2
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, empties the FIFO
//   flush      synchronous clear, same effect as rst, wins over push/pop
//   push       write wr_data this cycle (ignored when full)
//   wr_data    word to write
//   pop        retire the word at the head this cycle (ignored when empty)
//   rd_data    word at the head of the FIFO (undefined when empty)
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   occupancy  number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic do_push;
    logic do_pop;

    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // on their own when they overflow.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; an entry is
    // only ever read after it has been written, and keeping reset off the
    // array lets it map onto plain register-file / RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data   = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/sample_framer.sv
// -----------------------------------------------------------------------------
// sample_framer
//
// Upstream feeder for the peak-finding stage. Signed samples arrive on a
// valid/ready handshake and are buffered in a small FIFO. Each sample is
// clamped to zero when negative before it is stored, together with a flag
// recording that it was clamped. On the output side samples are grouped into
// frames of K: every sample carries its index in the frame plus first/last
// markers. When the last sample of a frame is accepted downstream, the number
// of clamped samples in that frame is published on frame_neg and frame_done
// pulses for one cycle, so the peak stage can latch its maximum.
//
// Parameters:
//   N      sample width in bits (two's complement, N <= 64)
//   K      samples per frame, 2..2**IDXW
//   DEPTH  FIFO entries, power of two, >= 2
//   IDXW   index width, ceil(log2(K))
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   flush       synchronous abort of the partial frame and all buffered data
//   in_valid    upstream sample valid
//   in_ready    framer accepts a sample this cycle
//   in_data     signed input sample
//   out_valid   a sample is presented to the peak stage
//   out_ready   peak stage accepts the presented sample
//   out_data    clamped sample (0 for negative inputs)
//   out_idx     position of out_data within its frame, 0..K-1
//   out_first   out_valid and out_idx == 0
//   out_last    out_valid and out_idx == K-1
//   frame_done  one-cycle pulse after the last sample of a frame is accepted
//   frame_neg   clamped-sample count of the most recently completed frame
// -----------------------------------------------------------------------------
module sample_framer
    import framer_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int K     = K_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int IDXW  = IDXW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_first,
    output logic            out_last,
    output logic            frame_done,
    output logic [IDXW:0]   frame_neg
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);
    localparam logic [IDXW:0]   NEG_MAX  = (IDXW + 1)'(K);

    // ------------------------------------------------------------------
    // Input side: clamp on the way in, store {clamped sample, neg flag}.
    // ------------------------------------------------------------------
    logic [N-1:0]  clamped;
    logic          in_neg;
    logic [N:0]    wr_entry;
    logic          push;

    assign clamped  = N'(clamp_nonneg(64'(in_data), N));
    assign in_neg   = in_data[N-1];
    assign wr_entry = {clamped, in_neg};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [N:0]  rd_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_level;
    logic        pop_fire;
    logic        rd_neg;

    sync_fifo #(
        .WIDTH (N + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .wr_data   (wr_entry),
        .pop       (pop_fire),
        .rd_data   (rd_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_level)
    );

    // Ready is withheld during rst and flush so nothing is accepted into a
    // FIFO that is being cleared on the same edge.
    assign in_ready  = ~fifo_full & ~rst & ~flush;
    assign push      = in_valid & in_ready;
    assign out_valid = (fifo_level != '0);

    // A pop that coincides with flush (or rst) is discarded: it neither
    // advances the frame counters nor contributes to frame_neg.
    assign pop_fire  = out_valid & out_ready & ~flush & ~rst;

    assign out_data  = rd_entry[N:1];
    assign rd_neg    = rd_entry[0];

    // ------------------------------------------------------------------
    // Frame tracking
    // ------------------------------------------------------------------
    logic [IDXW-1:0] idx;
    logic [IDXW:0]   neg_cnt;
    logic [IDXW:0]   neg_sum;
    logic [IDXW:0]   neg_next;
    logic            at_last;

    assign at_last  = (idx == LAST_IDX);
    assign neg_sum  = neg_cnt + (IDXW + 1)'(rd_neg);
    // A frame has at most K samples, so this limit only guards against a
    // mis-set K; in normal operation it never engages.
    assign neg_next = (neg_sum > NEG_MAX) ? NEG_MAX : neg_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            neg_cnt    <= '0;
            frame_neg  <= '0;
            frame_done <= 1'b0;
        end else begin
            // Registered pulse: asserted the cycle after the last pop.
            frame_done <= pop_fire & at_last;
            if (flush) begin
                // frame_neg keeps the last completed frame's count.
                idx     <= '0;
                neg_cnt <= '0;
            end else if (pop_fire) begin
                if (at_last) begin
                    idx       <= '0;
                    neg_cnt   <= '0;
                    frame_neg <= neg_next;
                end else begin
                    idx     <= idx + 1'b1;
                    neg_cnt <= neg_next;
                end
            end
        end
    end

    // idx only moves on an accepted pop, so index and markers stay stable
    // while the peak stage applies backpressure.
    assign out_idx   = idx;
    assign out_first = ~fifo_empty & (idx == '0);
    assign out_last  = ~fifo_empty & at_last;

endmodule

// File: tb/tb_sample_framer.sv
// -----------------------------------------------------------------------------
// tb_sample_framer
//
// Self-checking bench for sample_framer. A behavioural model (a queue of raw
// signed samples plus a count of samples taken from the current frame) predicts
// every output. Inputs change on the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_sample_framer;
    import framer_pkg::*;

    localparam int N     = N_DEFAULT;
    localparam int K     = K_DEFAULT;
    localparam int DEPTH = DEPTH_DEFAULT;
    localparam int IDXW  = IDXW_DEFAULT;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            flush     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [N-1:0]    in_data   = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    out_data;
    logic [IDXW-1:0] out_idx;
    logic            out_first;
    logic            out_last;
    logic            frame_done;
    logic [IDXW:0]   frame_neg;

    sample_framer #(
        .N     (N),
        .K     (K),
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_first  (out_first),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_neg  (frame_neg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    int model_q[$];          // raw signed samples waiting downstream
    int frame_pos    = 0;    // samples already taken from the current frame
    int neg_run      = 0;    // negative samples taken in the current frame
    int model_fneg   = 0;    // negatives in the last completed frame
    bit done_pending = 0;    // a frame completed at the previous edge

    // expectations for the cycle just sampled
    bit           exp_ready, exp_valid, exp_first, exp_last, exp_done;
    logic [N-1:0] exp_data;
    int           exp_idx;
    int           exp_fneg;
    bit           did_push, did_pop;

    int stim_q[$];

    // One clock cycle: drive inputs, form expectations from the model, then
    // advance the model by what the upcoming rising edge does.
    task automatic step(input logic v, input logic [N-1:0] d, input logic r,
                        input logic fl, input logic rs);
        @(negedge clk);
        rst = rs; flush = fl; in_valid = v; in_data = d; out_ready = r;
        #1;
        exp_ready = !rs && !fl && (model_q.size() < DEPTH);
        exp_valid = (model_q.size() != 0);
        exp_data  = '0;
        if (exp_valid && model_q[0] > 0) exp_data = N'(model_q[0]);
        exp_idx   = frame_pos;
        exp_first = exp_valid && (frame_pos == 0);
        exp_last  = exp_valid && (frame_pos == K - 1);
        exp_done  = done_pending;
        exp_fneg  = model_fneg;

        did_push     = v && exp_ready;
        did_pop      = exp_valid && r && !fl && !rs;
        done_pending = 0;
        if (rs) begin
            model_q.delete();
            frame_pos = 0; neg_run = 0; model_fneg = 0;
        end else if (fl) begin
            model_q.delete();
            frame_pos = 0; neg_run = 0;
        end else begin
            if (did_pop) begin
                if (model_q[0] < 0) neg_run++;
                void'(model_q.pop_front());
                frame_pos++;
                if (frame_pos == K) begin
                    model_fneg   = neg_run;
                    neg_run      = 0;
                    frame_pos    = 0;
                    done_pending = 1;
                end
            end
            if (did_push) model_q.push_back(int'($signed(d)));
        end
    endtask

    // Stream stim_q through the DUT and compare every output every cycle.
    // vmode: 0 valid always, 1 valid random.  rmode: 0 ready always,
    // 1 ready alternating, 2 ready random.
    task automatic run_stream(input string name, input int vmode, input int rmode);
        int sent = 0;
        int cyc = 0;
        int budget = 40 * stim_q.size() + 200;
        logic v, r;
        logic [N-1:0] d;
        while ((sent < stim_q.size() || model_q.size() != 0 || done_pending) && cyc < budget) begin
            v = (sent < stim_q.size()) && (vmode == 0 || $urandom_range(3, 0) != 0);
            r = (rmode == 0) || (rmode == 1 && cyc[0] == 1'b0) || (rmode == 2 && $urandom_range(1, 0) == 1);
            d = (sent < stim_q.size()) ? N'(stim_q[sent]) : N'($urandom);
            step(v, d, r, 1'b0, 1'b0);
            n_checks++;
            if ({in_ready, out_valid, out_first, out_last, frame_done} !==
                {exp_ready, exp_valid, exp_first, exp_last, exp_done}) begin
                n_errors++;
                $display("FAIL %s ctrl cyc %0d: rdy/vld/first/last/done got %b required %b", name, cyc,
                         {in_ready, out_valid, out_first, out_last, frame_done},
                         {exp_ready, exp_valid, exp_first, exp_last, exp_done});
            end
            n_checks++;
            if (frame_neg !== (IDXW + 1)'(exp_fneg)) begin
                n_errors++;
                $display("FAIL %s frame_neg cyc %0d: got %0d required %0d", name, cyc, frame_neg, exp_fneg);
            end
            if (exp_valid) begin
                n_checks++;
                if (out_data !== exp_data || out_idx !== IDXW'(exp_idx)) begin
                    n_errors++;
                    $display("FAIL %s data/idx cyc %0d: got %0d/%0d required %0d/%0d", name, cyc,
                             out_data, out_idx, exp_data, exp_idx);
                end
            end
            if (did_push) sent++;
            cyc++;
        end
        n_checks++;
        if (cyc >= budget) begin
            n_errors++;
            $display("FAIL %s timeout: got %0d cycles required < %0d", name, cyc, budget);
        end
        // frame_done must not stretch into a second cycle
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (frame_done !== exp_done) begin
            n_errors++;
            $display("FAIL %s done_width: got %b required %b", name, frame_done, exp_done);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({in_ready, out_valid, out_first, out_last, frame_done} !== 5'b00000 || frame_neg !== '0) begin
            n_errors++;
            $display("FAIL reset_state: rdy/vld/first/last/done got %b neg %0d required 00000 neg 0",
                     {in_ready, out_valid, out_first, out_last, frame_done}, frame_neg);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: rdy/vld got %b%b required 10", in_ready, out_valid);
        end
    endtask

    task automatic test_ramp_frame();
        stim_q.delete();
        for (int i = 1; i <= K; i++) stim_q.push_back(i);
        run_stream("ramp", 0, 0);
        n_checks++;
        if (frame_neg !== '0) begin
            n_errors++;
            $display("FAIL ramp_neg: got %0d required 0", frame_neg);
        end
    endtask

    task automatic test_clamp_frame();
        stim_q.delete();
        stim_q.push_back(-5);
        stim_q.push_back(7);
        stim_q.push_back(-32768);
        for (int i = 0; i < K - 3; i++) stim_q.push_back(3);
        run_stream("clamp", 0, 0);
        n_checks++;
        if (frame_neg !== (IDXW + 1)'(2)) begin
            n_errors++;
            $display("FAIL clamp_neg: got %0d required 2", frame_neg);
        end
    endtask

    task automatic test_backpressure_full();
        int accepted = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, N'(200 + model_q.size()), 1'b0, 1'b0, 1'b0);
            if (in_ready === 1'b1) accepted++;
        end
        n_checks++;
        if (accepted != DEPTH || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_pushes: got %0d pushes rdy %b required %0d pushes rdy 0", accepted, in_ready, DEPTH);
        end
        // single pop while full: no same-cycle slot for the waiting push
        step(1'b1, N'(200 + DEPTH), 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== N'(200) || out_idx !== '0) begin
            n_errors++;
            $display("FAIL full_pop: rdy %b vld %b data %0d idx %0d required 0 1 200 0",
                     in_ready, out_valid, out_data, out_idx);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1 || out_idx !== IDXW'(1) || out_data !== N'(201)) begin
            n_errors++;
            $display("FAIL after_pop: rdy %b idx %0d data %0d required 1 1 201", in_ready, out_idx, out_data);
        end
        stim_q.delete();
        run_stream("drain", 0, 0);
    endtask

    task automatic test_alternating();
        stim_q.delete();
        for (int i = 0; i < K; i++) stim_q.push_back(int'($signed(N'($urandom))));
        run_stream("alternate", 0, 1);
    endtask

    task automatic test_flush();
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        int kept_neg;
        logic [N-1:0] d;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);     // start from a clean frame
        while ((pushed < 25 || popped < 20) && cyc < 200) begin
            d = (pushed % 3 == 0) ? N'(-1 - $urandom_range(1000, 0)) : N'($urandom_range(30000, 1));
            step(pushed < 25, d, popped < 20, 1'b0, 1'b0);
            if (did_pop) begin
                n_checks++;
                if (out_data !== exp_data || out_idx !== IDXW'(exp_idx)) begin
                    n_errors++;
                    $display("FAIL flush_pre data/idx: got %0d/%0d required %0d/%0d",
                             out_data, out_idx, exp_data, exp_idx);
                end
            end
            if (did_push) pushed++;
            if (did_pop) popped++;
            cyc++;
        end
        kept_neg = model_fneg;
        step(1'b1, N'(77), 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== IDXW'(20) || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_cycle: vld %b idx %0d rdy %b required 1 20 0", out_valid, out_idx, in_ready);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || frame_neg !== (IDXW + 1)'(kept_neg)) begin
            n_errors++;
            $display("FAIL flush_after: vld %b done %b neg %0d required 0 0 %0d",
                     out_valid, frame_done, frame_neg, kept_neg);
        end
        stim_q.delete();
        for (int i = 0; i < K; i++) stim_q.push_back($urandom_range(500, 0));
        run_stream("post_flush", 0, 2);
        n_checks++;
        if (frame_neg !== '0) begin
            n_errors++;
            $display("FAIL post_flush_neg: got %0d required 0", frame_neg);
        end
    endtask

    task automatic test_random();
        stim_q.delete();
        for (int i = 0; i < 3 * K; i++) stim_q.push_back(int'($signed(N'($urandom))));
        run_stream("random", 1, 2);
    endtask

    task automatic test_rst_midframe();
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        while ((pushed < 10 || popped < 6) && cyc < 200) begin
            step(pushed < 10, N'($urandom), popped < 6 && pushed >= 6, 1'b0, 1'b0);
            if (did_push) pushed++;
            if (did_pop) popped++;
            cyc++;
        end
        step(1'b1, N'(5), 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, out_first, out_last, frame_done} !== 4'b0000 || frame_neg !== '0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid: vld/first/last/done %b neg %0d rdy %b required 0000 0 1",
                     {out_valid, out_first, out_last, frame_done}, frame_neg, in_ready);
        end
        stim_q.delete();
        for (int i = 0; i < K; i++) stim_q.push_back(int'($signed(N'($urandom))));
        run_stream("post_rst", 0, 0);
        n_checks++;
        if (IDX_LAST != IDXW'(K - 1) || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_rst_idle: vld %b required 0", out_valid);
        end
    endtask

    initial begin
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);     // bring the DUT out of X
        test_reset();
        test_ramp_frame();
        test_clamp_frame();
        test_backpressure_full();
        test_alternating();
        test_flush();
        test_random();
        test_rst_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
